mips_multicycle_ctrl: RTL and testbench

- Main control sequencer for the multicycle MIPS32 core variant: one shared memory for instruction and data, one ALU, with IR/MDR/A/B/ALUOut holding registers.
- Moore-style FSM that replaces the single-cycle combinational control decode.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Stalls on a memory-ready handshake and traps on illegal opcodes or memory timeout.
- Opcodes supported: R-type, lw, sw, beq, j, addi.

---
 rtl/mips_mc_pkg.sv | 70 +++++++
 rtl/mips_multicycle_ctrl_if.sv | 37 +++
 rtl/mem_wait_timer.sv | 37 +++
 rtl/mips_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: opcodes,
// FSM state encoding, datapath select encodings and the control word.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } srcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_e;

    typedef struct packed {
        logic   pc_write;
        logic   pc_write_cond;
        logic   i_or_d;
        logic   mem_read;
        logic   mem_write;
        logic   ir_write;
        logic   mem_to_reg;
        logic   reg_dst;
        logic   reg_write;
        logic   alu_src_a;
        srcb_e  alu_src_b;
        aluop_e alu_op;
        pcsrc_e pc_source;
        logic   instr_done;
    } ctrl_t;

    // States that hold a shared-memory access open and therefore count wait cycles.
    function automatic logic is_mem_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath (slave).
interface mips_multicycle_ctrl_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemToReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, illegal_op, mem_timeout
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, illegal_op, mem_timeout
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags when the
// configured limit is reached while the memory is still not ready.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic mem_ready,
    input  logic state_change,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAT        = {CNT_W{1'b1}};
    localparam logic             TIMEOUT_EN = (MEM_TIMEOUT != 0);

    logic [CNT_W-1:0] r_cnt;

    // Wait counter; saturates so a disabled timeout never wraps back through the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (state_change || mem_ready || !waiting) begin
            r_cnt <= '0;
        end else if (r_cnt != SAT) begin
            r_cnt <= r_cnt + ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign expired = TIMEOUT_EN && waiting && !mem_ready && (r_cnt == LIMIT);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS32 main control sequencer: Moore FSM (Mealy-qualified fetch)
// stepping each instruction through fetch/decode/execute/memory/writeback.
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_ctrl_if.master bus
);

    state_e r_state;
    state_e w_next;
    ctrl_t  w_ctrl;
    logic   w_set_illegal;
    logic   w_expired;
    logic   w_waiting;
    logic   w_state_change;
    logic   r_illegal_op;
    logic   r_mem_timeout;

    assign w_waiting      = is_mem_wait_state(r_state);
    assign w_state_change = (w_next != r_state);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .waiting      (w_waiting),
        .mem_ready    (bus.mem_ready),
        .state_change (w_state_change),
        .expired      (w_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky trap causes, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_illegal_op  <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_illegal_op  <= r_illegal_op | w_set_illegal;
            r_mem_timeout <= r_mem_timeout | w_expired;
        end
    end

    // Next-state and control decode; mem_ready beats an expiring wait counter.
    always_comb begin
        w_ctrl        = '0;
        w_next        = r_state;
        w_set_illegal = 1'b0;
        case (r_state)
            S_RESET: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.pc_source = PCSRC_ALU;
                w_ctrl.ir_write  = bus.mem_ready;
                w_ctrl.pc_write  = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_expired) begin
                    w_next = S_TRAP;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = SRCB_IMM_SH2;
                w_ctrl.alu_op    = ALUOP_ADD;
                case (bus.opcode)
                    OP_RTYPE: w_next = S_EXEC;
                    OP_LW:    w_next = S_MEMADR;
                    OP_SW:    w_next = S_MEMADR;
                    OP_BEQ:   w_next = S_BRANCH;
                    OP_J:     w_next = S_JUMP;
                    OP_ADDI:  w_next = S_ADDIEX;
                    default: begin
                        w_next        = S_TRAP;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                case (bus.opcode)
                    OP_LW:   w_next = S_MEMRD;
                    OP_SW:   w_next = S_MEMWR;
                    default: begin
                        w_next        = S_TRAP;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_MEMWB;
                end else if (w_expired) begin
                    w_next = S_TRAP;
                end else begin
                    w_next = S_MEMRD;
                end
            end
            S_MEMWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            S_MEMWR: begin
                w_ctrl.i_or_d     = 1'b1;
                w_ctrl.mem_write  = 1'b1;
                w_ctrl.instr_done = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_expired) begin
                    w_next = S_TRAP;
                end else begin
                    w_next = S_MEMWR;
                end
            end
            S_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_next           = S_ALUWB;
            end
            S_ALUWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = SRCB_REG;
                w_ctrl.alu_op        = ALUOP_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
                w_ctrl.instr_done    = 1'b1;
                w_next               = S_FETCH;
            end
            S_JUMP: begin
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = PCSRC_JUMP;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            S_ADDIEX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_next           = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
    end

    assign bus.PCWrite     = w_ctrl.pc_write;
    assign bus.PCWriteCond = w_ctrl.pc_write_cond;
    assign bus.IorD        = w_ctrl.i_or_d;
    assign bus.MemRead     = w_ctrl.mem_read;
    assign bus.MemWrite    = w_ctrl.mem_write;
    assign bus.IRWrite     = w_ctrl.ir_write;
    assign bus.MemToReg    = w_ctrl.mem_to_reg;
    assign bus.RegDst      = w_ctrl.reg_dst;
    assign bus.RegWrite    = w_ctrl.reg_write;
    assign bus.ALUSrcA     = w_ctrl.alu_src_a;
    assign bus.ALUSrcB     = w_ctrl.alu_src_b;
    assign bus.ALUOp       = w_ctrl.alu_op;
    assign bus.PCSource    = w_ctrl.pc_source;
    assign bus.instr_done  = w_ctrl.instr_done;
    assign bus.illegal_op  = r_illegal_op;
    assign bus.mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for the multicycle control sequencer
// (timeout limit shortened to 4 so the trap and race cases stay short).
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [18:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [18:0] E_ZERO, E_FW, E_FG, E_DEC, E_MEMADR, E_MEMRD, E_MEMWB;
    logic [18:0] E_MEMWR_W, E_MEMWR_G, E_EXEC, E_ALUWB, E_BRANCH, E_JUMP;
    logic [18:0] E_ADDIEX, E_ADDIWB, E_TRAP_ILL, E_TRAP_TO;

    // Control word, MSB first: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
    // MemToReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource instr_done illegal timeout
    function automatic logic [18:0] cv(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic rdst,
        input logic rw, input logic asa, input logic [1:0] asb,
        input logic [1:0] aop, input logic [1:0] psrc, input logic done,
        input logic ill, input logic to);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa,
                asb, aop, psrc, done, ill, to};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.instr_done,
                bus.illegal_op, bus.mem_timeout};
    endfunction

    task automatic check(input string name, input logic [18:0] exp);
        logic [18:0] got;
        got = obs();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", name, got, exp);
        end
    endtask

    task automatic step(input logic [5:0] op, input logic rdy,
                        input logic [18:0] exp, input string name);
        @(posedge clk);
        #1;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #1;
        check(name, exp);
    endtask

    task automatic add(input logic [5:0] op, input logic rdy,
                       input logic [18:0] exp, input string name);
        vec_t v;
        v.op   = op;
        v.rdy  = rdy;
        v.exp  = exp;
        v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        E_ZERO     = 19'h0;
        E_FW       = cv(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0);
        E_FG       = cv(1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0);
        E_DEC      = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,1'b0);
        E_MEMADR   = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0);
        E_MEMRD    = cv(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
        E_MEMWB    = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0);
        E_MEMWR_W  = cv(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
        E_MEMWR_G  = cv(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0);
        E_EXEC     = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0);
        E_ALUWB    = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0);
        E_BRANCH   = cv(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0,1'b0);
        E_JUMP     = cv(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0,1'b0);
        E_ADDIEX   = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0);
        E_ADDIWB   = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0);
        E_TRAP_ILL = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0);
        E_TRAP_TO  = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1);

        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b0;
        rst           = 1'b0;
        #2;
        check("reset_outputs", E_ZERO);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_state_after_release", E_ZERO);

        // R-type, 4 cycles
        add(6'h00, 1'b1, E_FG,      "r_fetch");
        add(6'h00, 1'b1, E_DEC,     "r_decode");
        add(6'h00, 1'b1, E_EXEC,    "r_exec");
        add(6'h00, 1'b1, E_ALUWB,   "r_aluwb");
        // addi, 4 cycles
        add(6'h08, 1'b1, E_FG,      "addi_fetch");
        add(6'h08, 1'b1, E_DEC,     "addi_decode");
        add(6'h08, 1'b1, E_ADDIEX,  "addi_ex");
        add(6'h08, 1'b1, E_ADDIWB,  "addi_wb");
        // lw with 3 wait cycles in MEMRD, 8 cycles
        add(6'h23, 1'b1, E_FG,      "lw_fetch");
        add(6'h23, 1'b1, E_DEC,     "lw_decode");
        add(6'h23, 1'b1, E_MEMADR,  "lw_memadr");
        add(6'h23, 1'b0, E_MEMRD,   "lw_memrd_wait1");
        add(6'h23, 1'b0, E_MEMRD,   "lw_memrd_wait2");
        add(6'h23, 1'b0, E_MEMRD,   "lw_memrd_wait3");
        add(6'h23, 1'b1, E_MEMRD,   "lw_memrd_done");
        add(6'h23, 1'b1, E_MEMWB,   "lw_memwb");
        // sw with one write wait
        add(6'h2B, 1'b1, E_FG,      "sw_fetch");
        add(6'h2B, 1'b1, E_DEC,     "sw_decode");
        add(6'h2B, 1'b1, E_MEMADR,  "sw_memadr");
        add(6'h2B, 1'b0, E_MEMWR_W, "sw_memwr_wait");
        add(6'h2B, 1'b1, E_MEMWR_G, "sw_memwr_done");
        // beq, 3 cycles
        add(6'h04, 1'b1, E_FG,      "beq_fetch");
        add(6'h04, 1'b1, E_DEC,     "beq_decode");
        add(6'h04, 1'b0, E_BRANCH,  "beq_branch");
        // j, 3 cycles
        add(6'h02, 1'b1, E_FG,      "j_fetch");
        add(6'h02, 1'b1, E_DEC,     "j_decode");
        add(6'h02, 1'b0, E_JUMP,    "j_jump");
        // fetch stall, ready arrives in the cycle the counter hits the limit
        for (int i = 0; i < 4; i++) add(6'h00, 1'b0, E_FW, "race_fetch_wait");
        add(6'h00, 1'b1, E_FG,      "race_fetch_ready_wins");
        add(6'h00, 1'b1, E_DEC,     "race_decode");
        add(6'h00, 1'b1, E_EXEC,    "race_exec");
        add(6'h00, 1'b1, E_ALUWB,   "race_aluwb");
        // fetch stall that runs out
        for (int i = 0; i < 5; i++) add(6'h00, 1'b0, E_FW, "to_fetch_wait");
        add(6'h00, 1'b1, E_TRAP_TO, "to_trap1");
        add(6'h00, 1'b0, E_TRAP_TO, "to_trap2");
        add(6'h00, 1'b1, E_TRAP_TO, "to_trap3");

        foreach (tbl[i]) step(tbl[i].op, tbl[i].rdy, tbl[i].exp, tbl[i].name);

        // Reset out of the timeout trap, then an illegal opcode
        #1;
        rst = 1'b0;
        #1;
        check("trap_reset_async", E_ZERO);
        @(negedge clk);
        rst = 1'b1;
        step(6'h3F, 1'b1, E_FG,  "ill_fetch");
        step(6'h3F, 1'b1, E_DEC, "ill_decode");
        for (int i = 0; i < 22; i++)
            step(6'h3F, 1'($urandom_range(1)), E_TRAP_ILL, "ill_trap_hold");

        // Reset in the middle of a stalled lw read
        #1;
        rst = 1'b0;
        #1;
        check("ill_reset_async", E_ZERO);
        @(negedge clk);
        rst = 1'b1;
        step(6'h23, 1'b1, E_FG,     "lwr_fetch");
        step(6'h23, 1'b1, E_DEC,    "lwr_decode");
        step(6'h23, 1'b1, E_MEMADR, "lwr_memadr");
        step(6'h23, 1'b0, E_MEMRD,  "lwr_memrd_wait1");
        step(6'h23, 1'b0, E_MEMRD,  "lwr_memrd_wait2");
        #1;
        rst = 1'b0;
        #1;
        check("memrd_reset_async", E_ZERO);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("memrd_reset_state", E_ZERO);
        step(6'h23, 1'b0, E_FW, "post_reset_fetch1");
        step(6'h23, 1'b0, E_FW, "post_reset_fetch2");
        step(6'h23, 1'b1, E_FG, "post_reset_fetch_go");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
